// File: rtl/yacht_pkg.sv
// Constants and state encoding for the dice game, shared by the roll sequencer,
// the game FSM and the scorer.
package yacht_pkg;

  localparam int NUM_DICE = 5;
  localparam logic [NUM_DICE-1:0] ALL_HELD = 5'b11111;
  localparam int DEFAULT_MAX_ROLLS = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ANIM = 2'd1,
    WAIT = 2'd2,
    FULL = 2'd3
  } roll_state_t;

endpackage

// File: rtl/btn_sync_edge.sv
// Push-button conditioner: 2-FF synchronizer, optional debounce, rising-edge pulse.
// Debounce is built only when ROLL_DEBOUNCE_EN is defined.
module btn_sync_edge #(
  parameter int DEB_CYCLES = 500_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn,
  output logic press
);

  logic btn_meta;
  logic btn_sync;
  logic level;
  logic level_prev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      btn_meta <= 1'b0;
      btn_sync <= 1'b0;
    end else begin
      btn_meta <= btn;
      btn_sync <= btn_meta;
    end
  end

`ifdef ROLL_DEBOUNCE_EN
  localparam int DW = $clog2(DEB_CYCLES + 1);

  logic [DW-1:0] deb_cnt;

  // The level only follows the synchronized input after DEB_CYCLES stable cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      deb_cnt <= '0;
      level   <= 1'b0;
    end else if (btn_sync == level) begin
      deb_cnt <= '0;
    end else if (deb_cnt == DW'(DEB_CYCLES - 1)) begin
      deb_cnt <= '0;
      level   <= btn_sync;
    end else begin
      deb_cnt <= deb_cnt + 1'b1;
    end
  end
`else
  assign level = btn_sync;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) level_prev <= 1'b0;
    else          level_prev <= level;
  end

  assign press = level & ~level_prev;

endmodule

// File: rtl/roll_sequencer.sv
// Per-turn roll controller: turns ROLL presses into timed roll_en bursts and counts rolls.
// Define ROLL_DEBOUNCE_EN to debounce the ROLL button (adds DEB_CYCLES of latency).
module roll_sequencer
  import yacht_pkg::*;
#(
  parameter int MAX_ROLLS   = DEFAULT_MAX_ROLLS,
  parameter int ANIM_PULSES = 12,
  parameter int ANIM_PERIOD = 2_500_000,
  parameter int DEB_CYCLES  = 500_000
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                roll_btn,
  input  logic [NUM_DICE-1:0] hold_sw,
  input  logic                score_done,
  output logic                roll_en,
  output logic [NUM_DICE-1:0] hold_out,
  output logic [1:0]          roll_cnt,
  output logic                rolling,
  output logic                can_score
);

  localparam int PW = (ANIM_PERIOD > 2) ? $clog2(ANIM_PERIOD) : 1;
  localparam int CW = $clog2(ANIM_PULSES + 1);
  localparam logic [PW-1:0] PERIOD_LAST = PW'(ANIM_PERIOD - 1);
  localparam logic [CW-1:0] PULSES_ALL  = CW'(ANIM_PULSES);
  localparam logic [1:0]    ROLLS_MAX   = 2'(MAX_ROLLS);

  roll_state_t state, state_next;
  logic [NUM_DICE-1:0] hold_meta, hold_sync, hold_next;
  logic [1:0]          roll_cnt_next;
  logic [PW-1:0]       period_cnt, period_next;
  logic [CW-1:0]       pulse_cnt, pulse_next;
  logic                press;

  btn_sync_edge #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_roll_btn (
    .clk    (clk),
    .reset_n(reset_n),
    .btn    (roll_btn),
    .press  (press)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_meta  <= '0;
      hold_sync  <= '0;
      state      <= IDLE;
      hold_out   <= '0;
      roll_cnt   <= 2'd0;
      period_cnt <= '0;
      pulse_cnt  <= '0;
    end else begin
      hold_meta  <= hold_sw;
      hold_sync  <= hold_meta;
      state      <= state_next;
      hold_out   <= hold_next;
      roll_cnt   <= roll_cnt_next;
      period_cnt <= period_next;
      pulse_cnt  <= pulse_next;
    end
  end

  // Counters rest at zero outside ANIM so every burst starts with a pulse.
  always_comb begin
    state_next    = state;
    hold_next     = hold_out;
    roll_cnt_next = roll_cnt;
    period_next   = '0;
    pulse_next    = '0;
    roll_en       = 1'b0;
    case (state)
      IDLE: begin
        roll_cnt_next = 2'd0;
        if (press) begin
          hold_next  = '0;
          state_next = ANIM;
        end
      end
      ANIM: begin
        if (pulse_cnt == PULSES_ALL) begin
          roll_cnt_next = roll_cnt + 2'd1;
          state_next    = (roll_cnt + 2'd1 == ROLLS_MAX) ? FULL : WAIT;
        end else begin
          period_next = (period_cnt == PERIOD_LAST) ? '0 : period_cnt + 1'b1;
          pulse_next  = pulse_cnt;
          if (period_cnt == '0) begin
            roll_en    = 1'b1;
            pulse_next = pulse_cnt + 1'b1;
          end
        end
      end
      WAIT: begin
        hold_next = hold_sync;
        if (score_done) begin
          roll_cnt_next = 2'd0;
          hold_next     = '0;
          state_next    = IDLE;
        end else if (press && hold_sync != ALL_HELD) begin
          state_next = ANIM;
        end
      end
      FULL: begin
        if (score_done) begin
          roll_cnt_next = 2'd0;
          hold_next     = '0;
          state_next    = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign rolling   = (state == ANIM);
  assign can_score = (roll_cnt != 2'd0) && (state != ANIM);

endmodule

// File: tb/tb_roll_sequencer.sv
// Directed self-checking bench for roll_sequencer (ANIM_PERIOD=4, ANIM_PULSES=3, MAX_ROLLS=3).
module tb_roll_sequencer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       roll_btn = 1'b0;
  logic [4:0] hold_sw = 5'b0;
  logic       score_done = 1'b0;
  logic       roll_en;
  logic [4:0] hold_out;
  logic [1:0] roll_cnt;
  logic       rolling;
  logic       can_score;

  int checks = 0;
  int errors = 0;

  roll_sequencer #(
    .MAX_ROLLS  (3),
    .ANIM_PULSES(3),
    .ANIM_PERIOD(4),
    .DEB_CYCLES (8)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .roll_btn  (roll_btn),
    .hold_sw   (hold_sw),
    .score_done(score_done),
    .roll_en   (roll_en),
    .hold_out  (hold_out),
    .roll_cnt  (roll_cnt),
    .rolling   (rolling),
    .can_score (can_score)
  );

  always #5 clk = ~clk;

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Presses ROLL for two cycles, then watches 16 cycles recording pulse timing
  // (cycles counted from the press) and whether hold_out stayed at exp_hold while rolling.
  task automatic burst(input logic [4:0] exp_hold, input bit toggle_hold,
                       output int n, output int first_at, output int last_at,
                       output bit hold_ok);
    logic [4:0] saved;
    n = 0; first_at = -1; last_at = -1; hold_ok = 1'b1;
    saved = hold_sw;
    @(negedge clk);
    roll_btn = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k == 2) roll_btn = 1'b0;
      if (toggle_hold && k == 5) hold_sw = ~saved;
      if (toggle_hold && k == 9) hold_sw = saved;
      if (roll_en) begin
        n++;
        if (first_at < 0) first_at = k;
        last_at = k;
      end
      if (rolling && hold_out !== exp_hold) hold_ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    idle_cycles(2);
    checks++;
    if ({roll_en, hold_out, roll_cnt, rolling, can_score} !== 10'b0) begin
      errors++;
      $display("[TB] FAIL reset_outputs got %b expected %b",
               {roll_en, hold_out, roll_cnt, rolling, can_score}, 10'b0);
    end
    reset_n = 1'b1;
    idle_cycles(2);
  endtask

  task automatic test_first_roll();
    int n, f, l; bit ok;
    hold_sw = 5'b10110;
    idle_cycles(3);
    burst(5'b00000, 1'b0, n, f, l, ok);
    checks++;
    if (n != 3 || f != 3 || l != 11) begin
      errors++;
      $display("[TB] FAIL first_roll_pulses got n=%0d first=%0d last=%0d expected n=3 first=3 last=11", n, f, l);
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL first_roll_hold got hold mismatch during burst expected 00000");
    end
    checks++;
    if (roll_cnt !== 2'd1 || rolling !== 1'b0 || can_score !== 1'b1) begin
      errors++;
      $display("[TB] FAIL first_roll_status got cnt=%0d rolling=%b can_score=%b expected 1 0 1",
               roll_cnt, rolling, can_score);
    end
    checks++;
    if (hold_out !== 5'b10110) begin
      errors++;
      $display("[TB] FAIL wait_tracks_hold got %b expected 10110", hold_out);
    end
  endtask

  task automatic test_hold_roll();
    int n, f, l; bit ok;
    hold_sw = 5'b00101;
    idle_cycles(3);
    burst(5'b00101, 1'b1, n, f, l, ok);
    checks++;
    if (n != 3 || f != 3 || l != 11) begin
      errors++;
      $display("[TB] FAIL hold_roll_pulses got n=%0d first=%0d last=%0d expected n=3 first=3 last=11", n, f, l);
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL hold_roll_mask got hold mismatch during burst expected 00101");
    end
    checks++;
    if (roll_cnt !== 2'd2) begin
      errors++;
      $display("[TB] FAIL hold_roll_cnt got %0d expected 2", roll_cnt);
    end
  endtask

  task automatic test_full();
    int n, f, l; bit ok;
    burst(5'b00101, 1'b0, n, f, l, ok);
    checks++;
    if (n != 3 || roll_cnt !== 2'd3 || rolling !== 1'b0 || can_score !== 1'b1) begin
      errors++;
      $display("[TB] FAIL third_roll got n=%0d cnt=%0d rolling=%b can_score=%b expected 3 3 0 1",
               n, roll_cnt, rolling, can_score);
    end
    burst(5'b00101, 1'b0, n, f, l, ok);
    checks++;
    if (n != 0 || roll_cnt !== 2'd3) begin
      errors++;
      $display("[TB] FAIL full_ignores_press got n=%0d cnt=%0d expected 0 3", n, roll_cnt);
    end
    score_done = 1'b1;
    @(negedge clk);
    score_done = 1'b0;
    checks++;
    if (roll_cnt !== 2'd0 || hold_out !== 5'b0 || can_score !== 1'b0) begin
      errors++;
      $display("[TB] FAIL full_score_done got cnt=%0d hold=%b can_score=%b expected 0 00000 0",
               roll_cnt, hold_out, can_score);
    end
  endtask

  task automatic test_all_held();
    int n, f, l; bit ok;
    hold_sw = 5'b00000;
    idle_cycles(3);
    burst(5'b00000, 1'b0, n, f, l, ok);
    hold_sw = 5'b11111;
    idle_cycles(3);
    burst(5'b11111, 1'b0, n, f, l, ok);
    checks++;
    if (n != 0 || roll_cnt !== 2'd1 || rolling !== 1'b0 || can_score !== 1'b1) begin
      errors++;
      $display("[TB] FAIL all_held_press got n=%0d cnt=%0d rolling=%b can_score=%b expected 0 1 0 1",
               n, roll_cnt, rolling, can_score);
    end
  endtask

  task automatic test_score_priority();
    int n;
    n = 0;
    hold_sw = 5'b00000;
    idle_cycles(3);
    roll_btn = 1'b1;
    idle_cycles(2);
    score_done = 1'b1;
    @(negedge clk);
    score_done = 1'b0;
    roll_btn = 1'b0;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      if (roll_en || rolling) n++;
    end
    checks++;
    if (n != 0 || roll_cnt !== 2'd0 || hold_out !== 5'b0) begin
      errors++;
      $display("[TB] FAIL score_beats_press got active=%0d cnt=%0d hold=%b expected 0 0 00000",
               n, roll_cnt, hold_out);
    end
    hold_sw = 5'b01010;
    idle_cycles(3);
    score_done = 1'b1;
    @(negedge clk);
    score_done = 1'b0;
    @(negedge clk);
    checks++;
    if ({roll_en, hold_out, roll_cnt, rolling, can_score} !== 10'b0) begin
      errors++;
      $display("[TB] FAIL idle_score_done got %b expected %b",
               {roll_en, hold_out, roll_cnt, rolling, can_score}, 10'b0);
    end
  endtask

  task automatic test_reset_mid_burst();
    int n;
    n = 0;
    @(negedge clk);
    roll_btn = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 2) roll_btn = 1'b0;
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (rolling !== 1'b0 || roll_en !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_mid_burst_async got rolling=%b roll_en=%b expected 0 0", rolling, roll_en);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (roll_en) n++;
    end
    reset_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (roll_en || rolling) n++;
    end
    checks++;
    if (n != 0 || roll_cnt !== 2'd0 || can_score !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_mid_burst_after got active=%0d cnt=%0d can_score=%b expected 0 0 0",
               n, roll_cnt, can_score);
    end
  endtask

  initial begin
    test_reset();
    test_first_roll();
    test_hold_roll();
    test_full();
    test_all_held();
    test_score_priority();
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
